// File: rtl/cpu_defs.sv
// Shared constants for the MCS8 pipeline: datapath widths and register indices.
package cpu_defs;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned CTRL_W_DEF = 16;
  localparam int unsigned NUM_REGS   = 7;

  localparam logic [IDX_W-1:0] REG_A = 3'd0;
  localparam logic [IDX_W-1:0] REG_B = 3'd1;
  localparam logic [IDX_W-1:0] REG_C = 3'd2;
  localparam logic [IDX_W-1:0] REG_D = 3'd3;
  localparam logic [IDX_W-1:0] REG_E = 3'd4;
  localparam logic [IDX_W-1:0] REG_H = 3'd5;
  localparam logic [IDX_W-1:0] REG_L = 3'd6;
  // M is the memory pseudo-register: never stored in the bank.
  localparam logic [IDX_W-1:0] REG_M = 3'd7;

endpackage

// File: rtl/cpu_decode_reg_if.sv
// D-stage / W-stage / E-stage signal bundle for cpu_decode_reg.
interface cpu_decode_reg_if
  import cpu_defs::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF
) ();

  logic              d_valid_i;
  logic [IDX_W-1:0]  d_srca_i;
  logic [IDX_W-1:0]  d_srcb_i;
  logic [IDX_W-1:0]  d_dst_i;
  logic              d_dstr_cs_i;
  logic              d_load_i;
  logic [CTRL_W-1:0] d_ctrl_i;
  logic [DATA_W-1:0] reg_bank_a_o;
  logic [DATA_W-1:0] reg_bank_b_o;
  logic [DATA_W-1:0] fwd_a_i;
  logic [DATA_W-1:0] fwd_b_i;
  logic              w_valid_i;
  logic              w_dstr_cs_i;
  logic [IDX_W-1:0]  w_dst_i;
  logic              w_dstr_cs_c_i;
  logic              w_dstr_cs_s_i;
  logic              w_dstr_cs_e_i;
  logic              w_dstr_cs_m_i;
  logic [DATA_W-1:0] w_val_c_i;
  logic [DATA_W-1:0] w_val_s_i;
  logic [DATA_W-1:0] w_val_e_i;
  logic [DATA_W-1:0] w_val_m_i;
  logic              stall_i;
  logic              flush_i;
  logic              stall_o;
  logic              e_valid_o;
  logic [DATA_W-1:0] e_val_a_o;
  logic [DATA_W-1:0] e_val_b_o;
  logic [IDX_W-1:0]  e_dst_o;
  logic              e_dstr_cs_o;
  logic              e_load_o;
  logic [CTRL_W-1:0] e_ctrl_o;

  modport master (
    output d_valid_i, d_srca_i, d_srcb_i, d_dst_i, d_dstr_cs_i, d_load_i, d_ctrl_i,
    output fwd_a_i, fwd_b_i,
    output w_valid_i, w_dstr_cs_i, w_dst_i,
    output w_dstr_cs_c_i, w_dstr_cs_s_i, w_dstr_cs_e_i, w_dstr_cs_m_i,
    output w_val_c_i, w_val_s_i, w_val_e_i, w_val_m_i,
    output stall_i, flush_i,
    input  reg_bank_a_o, reg_bank_b_o, stall_o,
    input  e_valid_o, e_val_a_o, e_val_b_o, e_dst_o, e_dstr_cs_o, e_load_o, e_ctrl_o
  );

  modport slave (
    input  d_valid_i, d_srca_i, d_srcb_i, d_dst_i, d_dstr_cs_i, d_load_i, d_ctrl_i,
    input  fwd_a_i, fwd_b_i,
    input  w_valid_i, w_dstr_cs_i, w_dst_i,
    input  w_dstr_cs_c_i, w_dstr_cs_s_i, w_dstr_cs_e_i, w_dstr_cs_m_i,
    input  w_val_c_i, w_val_s_i, w_val_e_i, w_val_m_i,
    input  stall_i, flush_i,
    output reg_bank_a_o, reg_bank_b_o, stall_o,
    output e_valid_o, e_val_a_o, e_val_b_o, e_dst_o, e_dstr_cs_o, e_load_o, e_ctrl_o
  );

endinterface

// File: rtl/cpu_regbank.sv
// 7x8 register bank: two raw asynchronous read ports, one write port with
// one-hot write-data select. Index M reads zero and is never written.
module cpu_regbank
  import cpu_defs::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [IDX_W-1:0]       raddr_a_i,
  input  logic [IDX_W-1:0]       raddr_b_i,
  output logic [DATA_W-1:0]      rdata_a_o,
  output logic [DATA_W-1:0]      rdata_b_o,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       waddr_i,
  input  logic [3:0]             wsel_i,
  input  logic [3:0][DATA_W-1:0] wval_i
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] wdata;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (wsel_i[i]) wdata = wdata | wval_i[i];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (we_i && (waddr_i != REG_M)) mem_d[waddr_i] = wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-edge contents; same-cycle bypass lives in cpu_forward.
  assign rdata_a_o = (raddr_a_i == REG_M) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == REG_M) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/cpu_decode_reg.sv
// MCS8 D stage: register bank, load-use hazard detection and the D->E
// pipeline register.
module cpu_decode_reg
  import cpu_defs::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input logic            clk_i,
  input logic            rstn_i,
  cpu_decode_reg_if.slave bus
);

  logic              e_valid_q,   e_valid_d;
  logic [DATA_W-1:0] e_val_a_q,   e_val_a_d;
  logic [DATA_W-1:0] e_val_b_q,   e_val_b_d;
  logic [IDX_W-1:0]  e_dst_q,     e_dst_d;
  logic              e_dstr_cs_q, e_dstr_cs_d;
  logic              e_load_q,    e_load_d;
  logic [CTRL_W-1:0] e_ctrl_q,    e_ctrl_d;
  logic              load_use;

  cpu_regbank u_regbank (
    .clk_i     (clk_i),
    .rst_ni    (rstn_i),
    .raddr_a_i (bus.d_srca_i),
    .raddr_b_i (bus.d_srcb_i),
    .rdata_a_o (bus.reg_bank_a_o),
    .rdata_b_o (bus.reg_bank_b_o),
    .we_i      (bus.w_valid_i & bus.w_dstr_cs_i),
    .waddr_i   (bus.w_dst_i),
    .wsel_i    ({bus.w_dstr_cs_m_i, bus.w_dstr_cs_e_i, bus.w_dstr_cs_s_i, bus.w_dstr_cs_c_i}),
    .wval_i    ({bus.w_val_m_i, bus.w_val_e_i, bus.w_val_s_i, bus.w_val_c_i})
  );

  // A load in E cannot be forwarded until M, so a dependent D must wait a cycle.
  always_comb begin
    load_use = bus.d_valid_i & e_valid_q & e_load_q & e_dstr_cs_q & ~bus.flush_i &
               ((e_dst_q == bus.d_srca_i) | (e_dst_q == bus.d_srcb_i));
  end

  always_comb begin
    e_valid_d   = e_valid_q;
    e_val_a_d   = e_val_a_q;
    e_val_b_d   = e_val_b_q;
    e_dst_d     = e_dst_q;
    e_dstr_cs_d = e_dstr_cs_q;
    e_load_d    = e_load_q;
    e_ctrl_d    = e_ctrl_q;
    if (bus.flush_i) begin
      e_valid_d   = 1'b0;
      e_val_a_d   = '0;
      e_val_b_d   = '0;
      e_dst_d     = '0;
      e_dstr_cs_d = 1'b0;
      e_load_d    = 1'b0;
      e_ctrl_d    = '0;
    end else if (bus.stall_i) begin
      // Downstream hold wins over the bubble; the stall reasserts on release.
    end else if (load_use) begin
      e_valid_d   = 1'b0;
      e_dstr_cs_d = 1'b0;
      e_load_d    = 1'b0;
    end else begin
      e_valid_d   = bus.d_valid_i;
      e_val_a_d   = bus.fwd_a_i;
      e_val_b_d   = bus.fwd_b_i;
      e_dst_d     = bus.d_dst_i;
      e_dstr_cs_d = bus.d_dstr_cs_i;
      e_load_d    = bus.d_load_i;
      e_ctrl_d    = bus.d_ctrl_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      e_valid_q   <= 1'b0;
      e_val_a_q   <= '0;
      e_val_b_q   <= '0;
      e_dst_q     <= '0;
      e_dstr_cs_q <= 1'b0;
      e_load_q    <= 1'b0;
      e_ctrl_q    <= '0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_val_a_q   <= e_val_a_d;
      e_val_b_q   <= e_val_b_d;
      e_dst_q     <= e_dst_d;
      e_dstr_cs_q <= e_dstr_cs_d;
      e_load_q    <= e_load_d;
      e_ctrl_q    <= e_ctrl_d;
    end
  end

  assign bus.stall_o     = load_use;
  assign bus.e_valid_o   = e_valid_q;
  assign bus.e_val_a_o   = e_val_a_q;
  assign bus.e_val_b_o   = e_val_b_q;
  assign bus.e_dst_o     = e_dst_q;
  assign bus.e_dstr_cs_o = e_dstr_cs_q;
  assign bus.e_load_o    = e_load_q;
  assign bus.e_ctrl_o    = e_ctrl_q;

endmodule

// File: tb/tb_cpu_decode_reg.sv
// Directed and random stimulus for cpu_decode_reg against a behavioural model.
module tb_cpu_decode_reg;

  localparam int unsigned CW = 16;

  typedef struct packed {
    logic          valid;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [2:0]    dst;
    logic          dstr;
    logic          load;
    logic [CW-1:0] ctrl;
  } e_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] bank_m [8];
  e_t         e_m;

  cpu_decode_reg_if #(.CTRL_W(CW)) bus ();

  cpu_decode_reg #(.CTRL_W(CW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] idx);
    return (idx == 3'd7) ? 8'h00 : bank_m[idx];
  endfunction

  function automatic logic m_stall();
    return bus.d_valid_i && e_m.valid && e_m.load && e_m.dstr && !bus.flush_i &&
           ((e_m.dst == bus.d_srca_i) || (e_m.dst == bus.d_srcb_i));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) bank_m[i] = 8'h00;
    e_m = '0;
  endtask

  task automatic m_step();
    logic       st;
    logic [7:0] wd;
    st = m_stall();
    if (bus.w_valid_i && bus.w_dstr_cs_i && bus.w_dst_i != 3'd7) begin
      wd = 8'h00;
      if (bus.w_dstr_cs_c_i) wd = wd | bus.w_val_c_i;
      if (bus.w_dstr_cs_s_i) wd = wd | bus.w_val_s_i;
      if (bus.w_dstr_cs_e_i) wd = wd | bus.w_val_e_i;
      if (bus.w_dstr_cs_m_i) wd = wd | bus.w_val_m_i;
      bank_m[bus.w_dst_i] = wd;
    end
    if (bus.flush_i) begin
      e_m = '0;
    end else if (bus.stall_i) begin
      e_m = e_m;
    end else if (st) begin
      e_m.valid = 1'b0;
      e_m.dstr  = 1'b0;
      e_m.load  = 1'b0;
    end else begin
      e_m = '{valid: bus.d_valid_i, a: bus.fwd_a_i, b: bus.fwd_b_i, dst: bus.d_dst_i,
              dstr: bus.d_dstr_cs_i, load: bus.d_load_i, ctrl: bus.d_ctrl_i};
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".bank_a"}, 32'(bus.reg_bank_a_o), 32'(m_read(bus.d_srca_i)));
    cmp({tag, ".bank_b"}, 32'(bus.reg_bank_b_o), 32'(m_read(bus.d_srcb_i)));
    cmp({tag, ".stall"},  32'(bus.stall_o),      32'(m_stall()));
    cmp({tag, ".e_valid"}, 32'(bus.e_valid_o),   32'(e_m.valid));
    cmp({tag, ".e_a"},    32'(bus.e_val_a_o),    32'(e_m.a));
    cmp({tag, ".e_b"},    32'(bus.e_val_b_o),    32'(e_m.b));
    cmp({tag, ".e_dst"},  32'(bus.e_dst_o),      32'(e_m.dst));
    cmp({tag, ".e_dstr"}, 32'(bus.e_dstr_cs_o),  32'(e_m.dstr));
    cmp({tag, ".e_load"}, 32'(bus.e_load_o),     32'(e_m.load));
    cmp({tag, ".e_ctrl"}, 32'(bus.e_ctrl_o),     32'(e_m.ctrl));
  endtask

  // Entered at posedge+1 (or negedge) with inputs driven; leaves at posedge+1.
  task automatic do_cycle(input string tag);
    #1;
    check_all(tag);
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.d_valid_i = 0; bus.d_srca_i = 0; bus.d_srcb_i = 0; bus.d_dst_i = 0;
    bus.d_dstr_cs_i = 0; bus.d_load_i = 0; bus.d_ctrl_i = '0;
    bus.fwd_a_i = 0; bus.fwd_b_i = 0;
    bus.w_valid_i = 0; bus.w_dstr_cs_i = 0; bus.w_dst_i = 0;
    bus.w_dstr_cs_c_i = 0; bus.w_dstr_cs_s_i = 0; bus.w_dstr_cs_e_i = 0; bus.w_dstr_cs_m_i = 0;
    bus.w_val_c_i = 0; bus.w_val_s_i = 0; bus.w_val_e_i = 0; bus.w_val_m_i = 0;
    bus.stall_i = 0; bus.flush_i = 0;
  endtask

  task automatic wb(input logic [2:0] dst, input logic [7:0] val);
    bus.w_valid_i = 1; bus.w_dstr_cs_i = 1; bus.w_dst_i = dst;
    bus.w_dstr_cs_e_i = 1; bus.w_val_e_i = val;
  endtask

  task automatic d_instr(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] dst,
                         input logic load);
    bus.d_valid_i = 1; bus.d_srca_i = sa; bus.d_srcb_i = sb; bus.d_dst_i = dst;
    bus.d_dstr_cs_i = 1; bus.d_load_i = load; bus.d_ctrl_i = 16'($urandom);
    bus.fwd_a_i = 8'($urandom); bus.fwd_b_i = 8'($urandom);
  endtask

  task automatic randomize_inputs();
    int k;
    bus.d_valid_i = 1'($urandom_range(0, 3) != 0);
    bus.d_srca_i = 3'($urandom_range(0, 7));
    bus.d_srcb_i = 3'($urandom_range(0, 3));
    bus.d_dst_i = 3'($urandom_range(0, 3));
    bus.d_dstr_cs_i = 1'($urandom);
    bus.d_load_i = 1'($urandom);
    bus.d_ctrl_i = 16'($urandom);
    bus.fwd_a_i = 8'($urandom); bus.fwd_b_i = 8'($urandom);
    bus.w_valid_i = 1'($urandom); bus.w_dstr_cs_i = 1'($urandom_range(0, 3) != 0);
    bus.w_dst_i = 3'($urandom_range(0, 7));
    k = $urandom_range(0, 4);
    bus.w_dstr_cs_c_i = (k == 0); bus.w_dstr_cs_s_i = (k == 1);
    bus.w_dstr_cs_e_i = (k == 2); bus.w_dstr_cs_m_i = (k == 3);
    bus.w_val_c_i = 8'($urandom); bus.w_val_s_i = 8'($urandom);
    bus.w_val_e_i = 8'($urandom); bus.w_val_m_i = 8'($urandom);
    bus.stall_i = ($urandom_range(0, 4) == 0);
    bus.flush_i = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    idle_inputs();
    m_reset();
    rstn = 0;
    #12;
    check_all("reset");
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;

    // Write B, read it back the following cycle.
    wb(3'd1, 8'h5A);
    bus.d_srca_i = 3'd1;
    do_cycle("t1_wr");
    idle_inputs();
    bus.d_srca_i = 3'd1;
    #1 cmp("t1_rd_lit", 32'(bus.reg_bank_a_o), 32'h5A);
    do_cycle("t1_rd");

    // Same-cycle write and read of C returns the old value.
    wb(3'd2, 8'h11);
    do_cycle("t2_pre");
    idle_inputs();
    wb(3'd2, 8'h33);
    bus.d_srca_i = 3'd2;
    #1 cmp("t2_old_lit", 32'(bus.reg_bank_a_o), 32'h11);
    do_cycle("t2_same");
    idle_inputs();
    bus.d_srca_i = 3'd2;
    #1 cmp("t2_new_lit", 32'(bus.reg_bank_a_o), 32'h33);
    do_cycle("t2_new");

    // Index M is not storage.
    wb(3'd7, 8'hFF);
    bus.d_srca_i = 3'd7;
    do_cycle("t3_wr");
    idle_inputs();
    bus.d_srca_i = 3'd7; bus.d_srcb_i = 3'd1;
    #1 cmp("t3_m_lit", 32'(bus.reg_bank_a_o), 32'h00);
    cmp("t3_b_lit", 32'(bus.reg_bank_b_o), 32'h5A);
    do_cycle("t3_rd");

    // Load-use: one bubble then advance.
    d_instr(3'd0, 3'd0, 3'd3, 1'b1);
    do_cycle("t4_ld");
    d_instr(3'd0, 3'd3, 3'd4, 1'b0);
    #1 cmp("t4_stall_lit", 32'(bus.stall_o), 32'd1);
    do_cycle("t4_use");
    cmp("t4_bubble_lit", 32'(bus.e_valid_o), 32'd0);
    do_cycle("t4_adv");
    cmp("t4_adv_valid_lit", 32'(bus.e_valid_o), 32'd1);
    cmp("t4_adv_dst_lit", 32'(bus.e_dst_o), 32'd4);

    // Downstream hold beats the bubble; bubble appears on release.
    d_instr(3'd0, 3'd0, 3'd3, 1'b1);
    do_cycle("t5_ld");
    d_instr(3'd3, 3'd0, 3'd5, 1'b0);
    bus.stall_i = 1;
    #1 cmp("t5_stall_lit", 32'(bus.stall_o), 32'd1);
    do_cycle("t5_hold");
    cmp("t5_hold_load_lit", 32'(bus.e_load_o), 32'd1);
    cmp("t5_hold_valid_lit", 32'(bus.e_valid_o), 32'd1);
    bus.stall_i = 0;
    do_cycle("t5_rel");
    cmp("t5_bubble_lit", 32'(bus.e_valid_o), 32'd0);
    cmp("t5_keep_dst_lit", 32'(bus.e_dst_o), 32'd3);

    // Flush overrides hold and masks the hazard.
    d_instr(3'd0, 3'd0, 3'd3, 1'b1);
    do_cycle("t6_ld");
    d_instr(3'd3, 3'd3, 3'd6, 1'b0);
    bus.stall_i = 1; bus.flush_i = 1;
    #1 cmp("t6_stall_lit", 32'(bus.stall_o), 32'd0);
    do_cycle("t6_flush");
    cmp("t6_valid_lit", 32'(bus.e_valid_o), 32'd0);
    cmp("t6_ctrl_lit", 32'(bus.e_ctrl_o), 32'd0);

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      do_cycle("rand");
    end

    // Asynchronous reset pulse between edges.
    randomize_inputs();
    bus.flush_i = 0;
    #1 rstn = 0;
    m_reset();
    #1 check_all("async_rst");
    cmp("async_rst_valid_lit", 32'(bus.e_valid_o), 32'd0);
    @(negedge clk);
    rstn = 1;
    idle_inputs();
    do_cycle("post_rst");
    for (int i = 0; i < 50; i++) begin
      randomize_inputs();
      do_cycle("rand2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
